// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipelined MIPS core.
// It serves M-stage loads and stores from an internal word-organised RAM.
// Each access takes WAIT_CYCLES wait states, then one RESP cycle carrying ack.
// stall holds the pipeline frozen from the request cycle until ack.
// Optional feature macro: DMEM_RANGE_CHECK_EN. When it is defined, accesses
// outside the BASE_ADDR window return err and are not performed.
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        stall,
    output logic        err
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT                 state;
    logic [3:0]            waitCnt;
    logic [ADDR_WIDTH-1:0] idxLat;
    logic [3:0]            wenLat;
    logic [31:0]           wdataLat;
    logic                  inRangeLat;
    logic [31:0]           mem [DEPTH];

    logic                  reqInRange;
    logic                  execute;
    logic                  doWrite;
    logic [ADDR_WIDTH-1:0] execIdx;
    logic [3:0]            execWen;
    logic [31:0]           execWdata;
    logic                  execInRange;

`ifdef DMEM_RANGE_CHECK_EN
    // Only the window selected by BASE_ADDR is backed by RAM.
    assign reqInRange = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // The byte offset within a word never selects anything.
    logic unusedAddr;
    assign unusedAddr = ^addr[1:0];
`else
    // Upper address bits are ignored, so the RAM aliases everywhere.
    assign reqInRange = 1'b1;

    logic unusedAddr;
    assign unusedAddr = ^{addr[31:ADDR_WIDTH+2], addr[1:0], BASE_ADDR};
`endif

    assign stall = req & ~ack;

    // The execute edge is the edge entering RESP.
    // With zero wait states it is also the accept edge.
    assign execute = ~rst & (((state == IDLE) & req & ZERO_WAIT) |
                             ((state == WAIT) & (waitCnt == 4'd1)));
    assign doWrite = execute & execInRange & (|execWen);

    // Use the live request on a zero-wait accept and the latched copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            execIdx     = addr[ADDR_WIDTH+1:2];
            execWen     = wen;
            execWdata   = wdata;
            execInRange = reqInRange;
        end else begin
            execIdx     = idxLat;
            execWen     = wenLat;
            execWdata   = wdataLat;
            execInRange = inRangeLat;
        end
    end

    // Capture the request at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idxLat     <= addr[ADDR_WIDTH+1:2];
            wenLat     <= wen;
            wdataLat   <= wdata;
            inRangeLat <= reqInRange;
        end
    end

    // Byte-lane RAM write on the execute edge of an in-range store; the RAM is not reset.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (execWen[b]) begin
                    mem[execIdx][8*b +: 8] <= execWdata[8*b +: 8];
                end
            end
        end
    end

    // Access FSM, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
            ack     <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        waitCnt <= 4'(WAIT_CYCLES);
                        state   <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            ack <= execute;
            if (execute) begin
                rdata <= ((execWen == 4'b0000) && execInRange) ? mem[execIdx] : 32'h0;
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    // Fault flag rides alongside ack for out-of-range accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= execute & ~execInRange;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: it serves the M-stage load/store request (word address, 4-bit byte write-enable, store data) from an internal word-organised RAM. It adds programmable wait states and drives a stall request so the hazard unit can freeze the pipeline until data is ready. It sits between the datapath's M-stage memory port and the rest of the SoC, as the responding end of the datapath's data-memory interface.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.
- BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; aligned to 2^(ADDR_WIDTH+2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  access request from M stage; held high until ack.
- addr  in  32  byte address (the M-stage ALU result); bits [1:0] are ignored.
- wen  in  4  byte write-enable; 4'b0000 = load, any other value = store; bit i writes wdata[8i+7:8i].
- wdata  in  32  store data, already byte-lane aligned by the datapath.
- rdata  out  32  load data; valid while ack=1.
- ack  out  1  one-cycle completion pulse.
- stall  out  1  pipeline freeze request to the hazard unit.
- err  out  1  access fault, qualified by ack.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On req=1, latch addr, wen and wdata, and load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 1, go to RESP on the next edge.
  - A req drop in WAIT is a protocol violation and is ignored; the access completes.
- **Execute edge** (the edge entering RESP)
  - Word index is latched addr[ADDR_WIDTH+1:2].
  - Load: rdata is registered from RAM.
  - Store: the enabled bytes are written into RAM and rdata is registered as 0.
- **RESP**: ack=1 and err is valid; the FSM goes to IDLE unconditionally.
- **Back-to-back**: req=1 in the IDLE cycle after RESP is treated as a new request. Minimum occupancy is WAIT_CYCLES+2 cycles per access.
- **stall** = req & ~ack (combinational), so stall is 1 from the request cycle through the last WAIT cycle and 0 in RESP.
- Inputs are sampled only at accept. Changes to addr, wen or wdata afterwards have no effect.

## Timing
- Access latency is fixed: ack is asserted WAIT_CYCLES+1 cycles after the accepting edge.
- **Reset values**: state=IDLE, counter=0, ack=0, rdata=32'h0, err=0, stall=req.
- RAM contents are not reset.
- **Reset mid-operation** (in WAIT or RESP): return to IDLE, ack=0 on the next cycle.
  - A store that has not reached its execute edge is dropped.
  - A store already executed remains in RAM.
- rst has priority over req in the same cycle.
- Word index wraps modulo 2^ADDR_WIDTH; there is no carry into the upper address bits.
- A store with wen=4'b1111 replaces the whole word. Partial wen leaves the other bytes unchanged.

## Configuration
- Macro: DMEM_RANGE_CHECK_EN.
- **Defined**
  - An access is in range only if addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
  - An out-of-range access runs the same FSM and latency but makes no RAM write and returns rdata=0.
  - err=1 together with ack.
  - In-range accesses give err=0.
- **Undefined**
  - The upper address bits are ignored, so the window aliases across the whole address space.
  - err is tied to 0.
  - The range-compare logic is not synthesised.

## Test plan
1. **Reset**: rst high 3 cycles with req=1 → ack=0, rdata=0, err=0, stall=1 throughout. After rst falls, the first ack comes WAIT_CYCLES+1 cycles after accept.
2. **Full-word store then load**
   - Store: WAIT_CYCLES=2, req with addr=0x10, wen=4'b1111, wdata=0xDEADBEEF → ack on cycle 3 after accept, rdata=0, stall high cycles 0–2.
   - Load: then req with addr=0x10, wen=0 → rdata=0xDEADBEEF with ack.
3. **Byte-lane store**: after step 2, store wen=4'b0100, wdata=0x00AA0000 to 0x10 → a following load returns 0xDEAABEEF.
4. **Zero wait and back-to-back**
   - With WAIT_CYCLES=0, req held high across 3 consecutive loads → ack every 2nd cycle, stall pattern 1,0,1,0,1,0.
   - With ADDR_WIDTH=10, addr=0x1000 (range check off) → aliases to word 0.
5. **Reset mid-access**: store to 0x20 with rst asserted in the WAIT cycle (WAIT_CYCLES=2) → no ack; a later load of 0x20 returns the pre-store value.
6. **Range check** (DMEM_RANGE_CHECK_EN defined, BASE_ADDR=0x0000_0000):
   - Store to 0x8000_0010 → ack with err=1; a later load of 0x10 is unchanged.
   - Load from 0x0000_0010 → err=0.
